j_mcount_p: RTL and testbench

Parametrised successor to the Jerry systolic multiply-width down-counter. It loads a width value and decrements once per enabled cycle. It flags a programmable early terminal value, so WIDTH=4 and EARLY=1 reproduce the legacy count1 strobe. New over the legacy block: selectable wrap/saturate/auto-reload modes, a shadow reload register, a registered terminal pulse, and a zero/wrap status. It sits in the Jerry DSP datapath sequencing systolic multiply-accumulate passes.

---
 rtl/j_mcount_p_if.sv | 25 ++
 rtl/j_mcount_p.sv | 69 ++++++
 tb/tb_j_mcount_p.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/j_mcount_p_if.sv
// Control and status bundle for the j_mcount_p down-counter.
// The master drives load/enable/mode; the slave (counter) returns count and flags.
interface j_mcount_p_if #(
    parameter int unsigned WIDTH = 4
);
    logic             cntld;
    logic             cnten;
    logic [WIDTH-1:0] mwidth;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             early;
    logic             zero;
    logic             done;
    logic             wrapped;

    modport master (
        output cntld, cnten, mwidth, mode,
        input  count, early, zero, done, wrapped
    );

    modport slave (
        input  cntld, cnten, mwidth, mode,
        output count, early, zero, done, wrapped
    );
endinterface

// File: rtl/j_mcount_p.sv
// Loadable down-counter sequencing systolic multiply passes, with wrap/saturate/auto-reload
// modes, shadow reload register, early/zero flags and registered done/wrapped pulses.
module j_mcount_p #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned EARLY = 1
) (
    input logic          clk,
    input logic          resetl,
    j_mcount_p_if.slave  bus
);
    localparam logic [WIDTH-1:0] EarlyVal = WIDTH'(EARLY);
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             done_q, done_d;
    logic             wrapped_q, wrapped_d;
    logic             reload_mode;

    assign reload_mode = (bus.mode == 2'b10);

    always_comb begin
        count_d   = count_q;
        shadow_d  = shadow_q;
        done_d    = 1'b0;
        wrapped_d = 1'b0;
        if (bus.cntld) begin
            count_d  = bus.mwidth;
            shadow_d = bus.mwidth;
        end else if (bus.cnten) begin
            if (count_q == One) begin
                done_d  = 1'b1;
                count_d = reload_mode ? shadow_q : '0;
            end else if (count_q == '0) begin
                // Reserved mode 11 falls into the saturate branch.
                case (bus.mode)
                    2'b00: begin
                        count_d   = '1;
                        wrapped_d = 1'b1;
                    end
                    2'b10:   count_d = shadow_q;
                    default: count_d = '0;
                endcase
            end else begin
                count_d = count_q - One;
            end
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            count_q   <= '0;
            shadow_q  <= '0;
            done_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            done_q    <= done_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.early   = (count_q == EarlyVal);
    assign bus.zero    = (count_q == '0);
    assign bus.done    = done_q;
    assign bus.wrapped = wrapped_q;
endmodule

// File: tb/tb_j_mcount_p.sv
// Randomised and directed bench for j_mcount_p (4-bit legacy and 8-bit instances)
// against an arithmetic reference model of the counting rules.
module tb_j_mcount_p;
    logic clk = 1'b0;
    logic resetl = 1'b0;
    always #5 clk = ~clk;

    j_mcount_p_if #(.WIDTH(4)) a_if ();
    j_mcount_p_if #(.WIDTH(8)) b_if ();

    j_mcount_p #(.WIDTH(4), .EARLY(1)) u_a (.clk(clk), .resetl(resetl), .bus(a_if));
    j_mcount_p #(.WIDTH(8), .EARLY(3)) u_b (.clk(clk), .resetl(resetl), .bus(b_if));

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state per instance
    int   a_cnt, a_sh, b_cnt, b_sh;
    logic a_dn, a_wr, b_dn, b_wr;

    task automatic model_next(input int w, input logic ld, input logic en, input int mw,
                              input logic [1:0] md, inout int cnt, inout int sh,
                              output logic dn, output logic wr);
        int top;
        top = (1 << w) - 1;
        dn  = 1'b0;
        wr  = 1'b0;
        if (ld) begin
            cnt = mw & top;
            sh  = mw & top;
        end else if (en) begin
            if (cnt > 1) begin
                cnt = cnt - 1;
            end else if (cnt == 1) begin
                dn  = 1'b1;
                cnt = (md == 2) ? sh : 0;
            end else if (md == 0) begin
                cnt = top;
                wr  = 1'b1;
            end else if (md == 2) begin
                cnt = sh;
            end
        end
    endtask

    task automatic model_reset();
        a_cnt = 0; a_sh = 0; a_dn = 0; a_wr = 0;
        b_cnt = 0; b_sh = 0; b_dn = 0; b_wr = 0;
    endtask

    function automatic logic [7:0] exp_a();
        return {4'(a_cnt), a_cnt == 1, a_cnt == 0, a_dn, a_wr};
    endfunction

    function automatic logic [11:0] exp_b();
        return {8'(b_cnt), b_cnt == 3, b_cnt == 0, b_dn, b_wr};
    endfunction

    function automatic logic [7:0] obs_a();
        return {a_if.count, a_if.early, a_if.zero, a_if.done, a_if.wrapped};
    endfunction

    function automatic logic [11:0] obs_b();
        return {b_if.count, b_if.early, b_if.zero, b_if.done, b_if.wrapped};
    endfunction

    task automatic step_a(input logic ld, input logic en, input int mw, input logic [1:0] md);
        @(negedge clk);
        a_if.cntld = ld; a_if.cnten = en; a_if.mwidth = 4'(mw); a_if.mode = md;
        @(posedge clk);
        model_next(4, ld, en, mw, md, a_cnt, a_sh, a_dn, a_wr);
        #1;
    endtask

    task automatic step_b(input logic ld, input logic en, input int mw, input logic [1:0] md);
        @(negedge clk);
        b_if.cntld = ld; b_if.cnten = en; b_if.mwidth = 8'(mw); b_if.mode = md;
        @(posedge clk);
        model_next(8, ld, en, mw, md, b_cnt, b_sh, b_dn, b_wr);
        #1;
    endtask

    task automatic test_reset();
        a_if.cntld = 0; a_if.cnten = 0; a_if.mwidth = '0; a_if.mode = 2'b00;
        b_if.cntld = 0; b_if.cnten = 0; b_if.mwidth = '0; b_if.mode = 2'b00;
        resetl = 1'b0;
        model_reset();
        #3;
        n_total++;
        if (obs_a() !== exp_a()) $display("FAIL reset_a: got %h want %h", obs_a(), exp_a());
        else n_pass++;
        n_total++;
        if (obs_b() !== exp_b()) $display("FAIL reset_b: got %h want %h", obs_b(), exp_b());
        else n_pass++;
        repeat (2) @(negedge clk);
        resetl = 1'b1;
    endtask

    task automatic test_wrap_legacy();
        step_a(1, 0, 5, 2'b00);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step_a(0, 1, 0, 2'b00);
            n_total++;
            if (obs_a() !== exp_a())
                $display("FAIL legacy_step%0d: got %h want %h", i, obs_a(), exp_a());
            else n_pass++;
            if (i == 5) begin
                n_total++;
                if ({a_if.count, a_if.done} !== {4'd0, 1'b1})
                    $display("FAIL legacy_done: got %h/%b want 0/1", a_if.count, a_if.done);
                else n_pass++;
            end
        end
        n_total++;
        if ({a_if.count, a_if.wrapped} !== {4'd15, 1'b1})
            $display("FAIL legacy_wrap: got %h/%b want f/1", a_if.count, a_if.wrapped);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int ndone = 0;
        step_a(1, 0, 3, 2'b01);
        for (int i = 0; i < 6; i++) begin
            step_a(0, 1, 0, 2'b01);
            if (a_if.done) ndone++;
            n_total++;
            if (obs_a() !== exp_a())
                $display("FAIL sat_step%0d: got %h want %h", i, obs_a(), exp_a());
            else n_pass++;
        end
        n_total++;
        if (ndone !== 1) $display("FAIL sat_done_count: got %0d want 1", ndone);
        else n_pass++;
    endtask

    task automatic test_reload();
        int ndone = 0;
        int last = 0;
        step_a(1, 0, 4, 2'b10);
        for (int i = 1; i <= 12; i++) begin
            step_a(0, 1, 0, 2'b10);
            n_total++;
            if (obs_a() !== exp_a())
                $display("FAIL reload_step%0d: got %h want %h", i, obs_a(), exp_a());
            else n_pass++;
            if (a_if.done) begin
                ndone++;
                n_total++;
                if (i - last !== 4) $display("FAIL reload_period: got %0d want 4", i - last);
                else n_pass++;
                last = i;
            end
        end
        n_total++;
        if (ndone !== 3) $display("FAIL reload_done_count: got %0d want 3", ndone);
        else n_pass++;
        step_a(1, 0, 0, 2'b10);
        for (int i = 0; i < 4; i++) begin
            step_a(0, 1, 0, 2'b10);
            n_total++;
            if (obs_a() !== exp_a())
                $display("FAIL reload0_step%0d: got %h want %h", i, obs_a(), exp_a());
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        step_a(1, 0, 2, 2'b00);
        step_a(1, 1, 9, 2'b00);
        n_total++;
        if ({a_if.count, a_if.done} !== {4'd9, 1'b0})
            $display("FAIL prio_load: got %h/%b want 9/0", a_if.count, a_if.done);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step_a(0, (i % 3) == 2, 0, 2'b00);
            n_total++;
            if (obs_a() !== exp_a())
                $display("FAIL prio_gap%0d: got %h want %h", i, obs_a(), exp_a());
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        step_a(1, 0, 9, 2'b10);
        step_a(0, 1, 0, 2'b10);
        step_a(0, 1, 0, 2'b10);
        n_total++;
        if (a_if.count !== 4'd7) $display("FAIL async_pre: got %h want 7", a_if.count);
        else n_pass++;
        #2;
        resetl = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (obs_a() !== exp_a()) $display("FAIL async_now: got %h want %h", obs_a(), exp_a());
        else n_pass++;
        @(negedge clk);
        resetl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_a(0, 1, 0, 2'b10);
            n_total++;
            if (obs_a() !== exp_a())
                $display("FAIL async_post%0d: got %h want %h", i, obs_a(), exp_a());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic ld, en;
        int mw;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            mw = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            step_a(ld, en, mw, 2'($urandom_range(0, 3)));
            n_total++;
            if (obs_a() !== exp_a())
                $display("FAIL rand_a%0d: got %h want %h", i, obs_a(), exp_a());
            else n_pass++;
        end
    endtask

    task automatic test_wide();
        logic ld, en;
        step_b(1, 0, 0, 2'b00);
        step_b(0, 1, 0, 2'b00);
        n_total++;
        if ({b_if.count, b_if.wrapped} !== {8'd255, 1'b1})
            $display("FAIL wide_wrap: got %h/%b want ff/1", b_if.count, b_if.wrapped);
        else n_pass++;
        step_b(1, 0, 4, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step_b(0, 1, 0, 2'b00);
            n_total++;
            if (obs_b() !== exp_b())
                $display("FAIL wide_dec%0d: got %h want %h", i, obs_b(), exp_b());
            else n_pass++;
        end
        for (int i = 0; i < 200; i++) begin
            ld = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 3) != 0);
            step_b(ld, en, $urandom_range(0, 6), 2'($urandom_range(0, 3)));
            n_total++;
            if (obs_b() !== exp_b())
                $display("FAIL rand_b%0d: got %h want %h", i, obs_b(), exp_b());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_wrap_legacy();
        test_saturate();
        test_reload();
        test_priority();
        test_async_reset();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
